csr_commit_ctrl: RTL and testbench
==================================

# csr_commit_ctrl

Commit-side controller sitting between the WB pipeline stage and the CSR file. It arbitrates each retiring instruction into exactly one of three outcomes: a plain CSR write, an exception commit, or an `ertn` return. It latches pending interrupts and attaches them to the next retiring instruction. It sequences the front-end redirect/squash handshake, and holds WB commits off until that handshake has completed.

## Interface
Parameters:
- `MIN_SQUASH`, default 2: minimum number of cycles spent in REDIR, which is the squash window for younger instructions.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `wb_valid` in 1: WB holds a retiring instruction this cycle.
- `wb_pc` in 32: PC of the WB instruction.
- `wb_vaddr` in 32: memory virtual address of the WB instruction (load/store).
- `wb_exc` in 5: exception flags, [4] ADEF, [3] INE, [2] SYS, [1] BRK, [0] ALE.
- `wb_ertn` in 1: the WB instruction is `ertn`.
- `wb_csr_we` in 1: the WB instruction writes a CSR.
- `wb_csr_num` in 14: CSR number to write.
- `wb_csr_wmask` in 32: CSR write mask.
- `wb_csr_wvalue` in 32: CSR write value.
- `has_int` in 1: interrupt-pending indication from the CSR file (already masked by ECFG.LIE and CRMD.IE).
- `ex_entry` in 32: exception entry address (EENTRY).
- `ertn_entry` in 32: return address (ERA).
- `flush_ack` in 1: front end has taken the redirect.
- `wb_allowin` out 1: WB may present or advance an instruction.
- `csr_we` out 1: CSR write enable to the CSR file.
- `csr_num` out 14: CSR number to the CSR file.
- `csr_wmask` out 32: CSR write mask to the CSR file.
- `csr_wvalue` out 32: CSR write value to the CSR file.
- `wb_ex` out 1: exception commit pulse.
- `wb_ecode` out 6: exception code.
- `wb_esubcode` out 9: exception subcode.
- `ex_pc` out 32: PC of the excepting instruction.
- `ex_vaddr` out 32: bad virtual address for the exception.
- `ertn_flush` out 1: `ertn` commit pulse.
- `flush_valid` out 1: redirect/squash request to the front end and the pipeline.
- `flush_target` out 32: redirect target PC.

## Operation
FSM has two states, IDLE and REDIR. Reset state is IDLE.

Interrupt latch:
- `int_pend` is a register. Each cycle it loads `has_int` when the state is IDLE and no exception commits this cycle; otherwise it loads 0.

Acceptance:
- `accept = wb_valid & state==IDLE`.
- `exc_any = int_pend | (|wb_exc)`.

Exception priority and codes, first match wins:
- INT: ecode 0x00.
- ADEF: ecode 0x08, esubcode 0.
- INE: ecode 0x0D.
- SYS: ecode 0x0B.
- BRK: ecode 0x0C.
- ALE: ecode 0x09.
- esubcode is 0 for all of them.

Outcomes for an accepted instruction:
- Exception commit (`accept & exc_any`):
  - `wb_ex=1` and `ex_pc=wb_pc`.
  - `ex_vaddr = ADEF ? wb_pc : wb_vaddr`.
  - The CSR write is suppressed and `ertn` is ignored.
  - `flush_target` captures `ex_entry`; the state goes to REDIR.
- Return (`accept & ~exc_any & wb_ertn`):
  - `ertn_flush=1`.
  - `flush_target` captures `ertn_entry`; the state goes to REDIR.
- Plain commit (`accept & ~exc_any & ~wb_ertn`):
  - `csr_we = wb_csr_we`, with `csr_num`, `csr_wmask` and `csr_wvalue` passed through.
  - The state stays IDLE.

REDIR state:
- `flush_valid=1`, and `flush_target` is held.
- `wb_allowin=1`; any `wb_valid` is squashed, with no CSR write, no `wb_ex` and no `ertn_flush`.
- A cycle counter `sq_cnt` is cleared on entry and increments every cycle, saturating at `MIN_SQUASH`.
- Exit to IDLE on the first cycle with `flush_ack & sq_cnt >= MIN_SQUASH-1`.
- `flush_ack` received while in IDLE is ignored.

## Timing
Reset values:
- `flush_valid=0`, `flush_target=0`, `int_pend=0`, state IDLE.
- All pulse outputs are 0 during reset.

Combinational outputs (same cycle as accept):
- `csr_we`, `wb_ex`, `ertn_flush`, `wb_ecode`, `wb_esubcode`, `ex_pc`, `ex_vaddr`.
- The CSR file captures them on the following edge.

Registered outputs:
- `flush_valid` rises the cycle after the exception or return commit.
- REDIR lasts at least `MIN_SQUASH` cycles; after that it lasts until `flush_ack`.

Interrupt latency:
- `has_int` high at cycle t becomes `int_pend` at t+1.
- An instruction accepted at t+1 or later takes INT.

Boundary cases:
- Consecutive exceptions are impossible: the second instruction arrives during REDIR and is squashed.
- `has_int` high during REDIR does not latch; it is re-sampled in the first IDLE cycle.
- Exception and `ertn` in the same instruction: the exception wins.
- `reset` asserted during REDIR returns the block to IDLE the next cycle with `flush_valid=0`.

Outputs when inactive:
- `wb_allowin` is 1 in both states.
- When there is no accept, `csr_we=0` and `ex_*`/`ecode` outputs are 0.

## Test plan
- Plain write: wb_valid, csr_we, num 0x30, wmask 0xFFFFFFFF, wvalue 0x1234 -> same-cycle `csr_we=1` with the identical fields; `flush_valid` stays 0.
- SYS at pc 0x1C000100, ex_entry 0x1C008000 -> `wb_ex=1`, ecode 0x0B, `ex_pc=0x1C000100`, `csr_we=0`. Next cycle `flush_valid=1` with `flush_target=0x1C008000`. With `flush_ack` held at 1 and MIN_SQUASH=2, IDLE is re-entered after 2 REDIR cycles.
- Priority: `wb_exc=5'b10011` with int_pend=0 -> ecode 0x08, `ex_vaddr=wb_pc`. `wb_exc=5'b00001` with vaddr 0x80000003 -> ecode 0x09, `ex_vaddr=0x80000003`.
- Interrupt: `has_int` pulses at t, then an instruction is accepted at t+1 with `wb_exc=0` and `wb_ertn=1` -> ecode 0x00, no `ertn_flush`, `int_pend` cleared.
- `ertn` with ertn_entry 0x1C000200 -> `ertn_flush=1`, then `flush_target=0x1C000200`. A `wb_valid` with csr_we during REDIR produces `csr_we=0`.
- Reset in REDIR: `reset` asserted while `flush_valid=1` -> next cycle `flush_valid=0`, state IDLE, and a following plain write commits normally.

Source files
------------

// File: rtl/csr_commit_ctrl.sv
// csr_commit_ctrl
// Commit-side controller between the WB stage and the CSR file. Each retiring
// instruction resolves to exactly one outcome: a plain CSR write, an exception
// commit, or an ertn return. Pending interrupts are latched and attached to
// the next retiring instruction. Exception and ertn commits start a
// redirect/squash window toward the front end.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   wb_*  (in)            retiring instruction from WB: valid, pc, vaddr,
//                         exception flags {ADEF,INE,SYS,BRK,ALE}, ertn, CSR write fields
//   has_int               masked interrupt-pending indication from the CSR file
//   ex_entry, ertn_entry  redirect targets for an exception / ertn
//   flush_ack             front end has taken the redirect
//   wb_allowin            WB may present or advance (always 1)
//   csr_*  (out)          CSR write port, valid only on a plain commit
//   wb_ex, wb_ecode, wb_esubcode, ex_pc, ex_vaddr   exception commit info
//   ertn_flush            ertn commit pulse
//   flush_valid, flush_target                      redirect request and target
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | accepting retiring instructions
// REDIR | redirect asserted, younger WB instructions squashed

module csr_commit_ctrl #(
    parameter int MIN_SQUASH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_vaddr,
    input  logic [4:0]  wb_exc,
    input  logic        wb_ertn,
    input  logic        wb_csr_we,
    input  logic [13:0] wb_csr_num,
    input  logic [31:0] wb_csr_wmask,
    input  logic [31:0] wb_csr_wvalue,
    input  logic        has_int,
    input  logic [31:0] ex_entry,
    input  logic [31:0] ertn_entry,
    input  logic        flush_ack,
    output logic        wb_allowin,
    output logic        csr_we,
    output logic [13:0] csr_num,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wvalue,
    output logic        wb_ex,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_vaddr,
    output logic        ertn_flush,
    output logic        flush_valid,
    output logic [31:0] flush_target
);

    localparam int CW = (MIN_SQUASH < 2) ? 1 : $clog2(MIN_SQUASH + 1);
    localparam logic [CW-1:0] SQ_MAX  = CW'(MIN_SQUASH);
    localparam logic [CW-1:0] SQ_EXIT = CW'(MIN_SQUASH - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_REDIR = 1'b1;

    logic [0:0]    state_q, state_d;
    logic          int_pend_q, int_pend_d;
    logic [31:0]   flush_target_q, flush_target_d;
    logic [CW-1:0] sq_cnt_q, sq_cnt_d;

    logic       accept;
    logic       exc_any;
    logic       ex_commit;
    logic       ertn_commit;
    logic       plain_commit;
    logic [5:0] ecode_sel;

    // Reset is folded into accept so no pulse escapes during a reset cycle,
    // even when the state register still reads REDIR.
    assign accept       = wb_valid & (state_q == S_IDLE) & ~reset;
    assign exc_any      = int_pend_q | (|wb_exc);
    assign ex_commit    = accept & exc_any;
    assign ertn_commit  = accept & ~exc_any & wb_ertn;
    assign plain_commit = accept & ~exc_any & ~wb_ertn;

    always_comb begin
        ecode_sel = 6'h00;
        if (int_pend_q)     ecode_sel = 6'h00;
        else if (wb_exc[4]) ecode_sel = 6'h08;
        else if (wb_exc[3]) ecode_sel = 6'h0D;
        else if (wb_exc[2]) ecode_sel = 6'h0B;
        else if (wb_exc[1]) ecode_sel = 6'h0C;
        else if (wb_exc[0]) ecode_sel = 6'h09;
    end

    assign wb_allowin  = 1'b1;
    assign csr_we      = plain_commit & wb_csr_we;
    assign csr_num     = plain_commit ? wb_csr_num    : 14'h0;
    assign csr_wmask   = plain_commit ? wb_csr_wmask  : 32'h0;
    assign csr_wvalue  = plain_commit ? wb_csr_wvalue : 32'h0;
    assign wb_ex       = ex_commit;
    assign wb_ecode    = ex_commit ? ecode_sel : 6'h00;
    assign wb_esubcode = 9'h000;
    assign ex_pc       = ex_commit ? wb_pc : 32'h0;
    // ADEF reports the fetch PC as the bad address, everything else the data address.
    assign ex_vaddr    = ex_commit ? (wb_exc[4] ? wb_pc : wb_vaddr) : 32'h0;
    assign ertn_flush  = ertn_commit;

    assign flush_valid  = (state_q == S_REDIR);
    assign flush_target = flush_target_q;

    // An interrupt attached to a committing exception is consumed, and
    // interrupts seen during REDIR are dropped until IDLE re-samples them.
    assign int_pend_d = ((state_q == S_IDLE) & ~ex_commit) ? has_int : 1'b0;

    always_comb begin
        state_d        = state_q;
        sq_cnt_d       = sq_cnt_q;
        flush_target_d = flush_target_q;
        case (state_q)
            S_IDLE: begin
                if (ex_commit) begin
                    state_d        = S_REDIR;
                    sq_cnt_d       = '0;
                    flush_target_d = ex_entry;
                end else if (ertn_commit) begin
                    state_d        = S_REDIR;
                    sq_cnt_d       = '0;
                    flush_target_d = ertn_entry;
                end
            end
            S_REDIR: begin
                if (sq_cnt_q != SQ_MAX) sq_cnt_d = sq_cnt_q + 1'b1;
                if (flush_ack && (sq_cnt_q >= SQ_EXIT)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            int_pend_q     <= 1'b0;
            flush_target_q <= 32'h0;
            sq_cnt_q       <= '0;
        end else begin
            state_q        <= state_d;
            int_pend_q     <= int_pend_d;
            flush_target_q <= flush_target_d;
            sq_cnt_q       <= sq_cnt_d;
        end
    end

endmodule

// File: tb/tb_csr_commit_ctrl.sv
module tb_csr_commit_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [31:0] wb_vaddr;
    logic [4:0]  wb_exc;
    logic        wb_ertn;
    logic        wb_csr_we;
    logic [13:0] wb_csr_num;
    logic [31:0] wb_csr_wmask;
    logic [31:0] wb_csr_wvalue;
    logic        has_int;
    logic [31:0] ex_entry;
    logic [31:0] ertn_entry;
    logic        flush_ack;
    logic        wb_allowin;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] ex_pc;
    logic [31:0] ex_vaddr;
    logic        ertn_flush;
    logic        flush_valid;
    logic [31:0] flush_target;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] EX_ENTRY   = 32'h1C00_8000;
    localparam logic [31:0] ERTN_ENTRY = 32'h1C00_0200;

    csr_commit_ctrl #(.MIN_SQUASH(2)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .wb_exc(wb_exc),
        .wb_ertn(wb_ertn), .wb_csr_we(wb_csr_we), .wb_csr_num(wb_csr_num),
        .wb_csr_wmask(wb_csr_wmask), .wb_csr_wvalue(wb_csr_wvalue),
        .has_int(has_int), .ex_entry(ex_entry), .ertn_entry(ertn_entry),
        .flush_ack(flush_ack), .wb_allowin(wb_allowin), .csr_we(csr_we),
        .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .ex_pc(ex_pc), .ex_vaddr(ex_vaddr), .ertn_flush(ertn_flush),
        .flush_valid(flush_valid), .flush_target(flush_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] va;
        logic [4:0]  exc;
        logic        ertn;
        logic        we;
        logic [13:0] num;
        logic [31:0] mask;
        logic [31:0] val;
        logic        e_we;
        logic        e_ex;
        logic [5:0]  e_ecode;
        logic [31:0] e_va;
        logic        e_ertn;
        logic        e_redir;
        logic [31:0] e_tgt;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle well before the next edge.
    task automatic settle();
        #2;
    endtask

    task automatic quiet_inputs();
        wb_valid      = 1'b0;
        wb_pc         = 32'h0;
        wb_vaddr      = 32'h0;
        wb_exc        = 5'b0;
        wb_ertn       = 1'b0;
        wb_csr_we     = 1'b0;
        wb_csr_num    = 14'h0;
        wb_csr_wmask  = 32'h0;
        wb_csr_wvalue = 32'h0;
        has_int       = 1'b0;
    endtask

    task automatic return_idle(input string name);
        flush_ack = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (!flush_valid) break;
            tick();
        end
        check(name, {31'b0, flush_valid}, 32'h0);
        flush_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                v  pc            va            exc      ertn we  num     mask          val           e_we e_ex ecode  e_va          e_ertn redir tgt
        vecs[0] = '{1'b1, 32'h1C00_0010, 32'h0,        5'b00000, 1'b0, 1'b1, 14'h30, 32'hFFFF_FFFF, 32'h1234,   1'b1, 1'b0, 6'h00, 32'h0,        1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h1C00_0014, 32'h0,        5'b00000, 1'b0, 1'b1, 14'h31, 32'hFFFF_FFFF, 32'h5,      1'b0, 1'b0, 6'h00, 32'h0,        1'b0, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 32'h1C00_0018, 32'h0,        5'b00000, 1'b0, 1'b0, 14'h32, 32'h0000_00FF, 32'h7,      1'b0, 1'b0, 6'h00, 32'h0,        1'b0, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 32'h1C00_0040, 32'h0000_0055, 5'b10011, 1'b0, 1'b1, 14'h30, 32'hFFFF_FFFF, 32'h9,      1'b0, 1'b1, 6'h08, 32'h1C00_0040, 1'b0, 1'b1, EX_ENTRY};
        vecs[4] = '{1'b1, 32'h1C00_0044, 32'h8000_0003, 5'b00001, 1'b0, 1'b0, 14'h0,  32'h0,         32'h0,      1'b0, 1'b1, 6'h09, 32'h8000_0003, 1'b0, 1'b1, EX_ENTRY};
        vecs[5] = '{1'b1, 32'h1C00_0048, 32'h0000_1000, 5'b01000, 1'b0, 1'b0, 14'h0,  32'h0,         32'h0,      1'b0, 1'b1, 6'h0D, 32'h0000_1000, 1'b0, 1'b1, EX_ENTRY};
        vecs[6] = '{1'b1, 32'h1C00_004C, 32'h0000_2000, 5'b00110, 1'b0, 1'b0, 14'h0,  32'h0,         32'h0,      1'b0, 1'b1, 6'h0B, 32'h0000_2000, 1'b0, 1'b1, EX_ENTRY};
        vecs[7] = '{1'b1, 32'h1C00_0050, 32'h0000_3000, 5'b00010, 1'b0, 1'b0, 14'h0,  32'h0,         32'h0,      1'b0, 1'b1, 6'h0C, 32'h0000_3000, 1'b0, 1'b1, EX_ENTRY};
        vecs[8] = '{1'b1, 32'h1C00_0100, 32'h0000_4000, 5'b00100, 1'b1, 1'b1, 14'h30, 32'hFFFF_FFFF, 32'hAA,     1'b0, 1'b1, 6'h0B, 32'h0000_4000, 1'b0, 1'b1, EX_ENTRY};
        vecs[9] = '{1'b1, 32'h1C00_0104, 32'h0,        5'b00000, 1'b1, 1'b0, 14'h0,  32'h0,         32'h0,      1'b0, 1'b0, 6'h00, 32'h0,        1'b1, 1'b1, ERTN_ENTRY};

        quiet_inputs();
        ex_entry   = EX_ENTRY;
        ertn_entry = ERTN_ENTRY;
        flush_ack  = 1'b0;
        reset      = 1'b1;

        // Reset: pulses held low even with a write presented.
        tick();
        wb_valid = 1'b1; wb_csr_we = 1'b1; wb_csr_num = 14'h30;
        tick();
        settle();
        check("rst_flush_valid", {31'b0, flush_valid}, 32'h0);
        check("rst_flush_target", flush_target, 32'h0);
        check("rst_csr_we", {31'b0, csr_we}, 32'h0);
        check("rst_wb_allowin", {31'b0, wb_allowin}, 32'h1);
        quiet_inputs();
        reset = 1'b0;
        tick();

        // Table: single-instruction outcomes from IDLE with no pending interrupt.
        for (int i = 0; i < 10; i++) begin
            wb_valid = vecs[i].v;   wb_pc = vecs[i].pc;      wb_vaddr = vecs[i].va;
            wb_exc = vecs[i].exc;   wb_ertn = vecs[i].ertn;  wb_csr_we = vecs[i].we;
            wb_csr_num = vecs[i].num; wb_csr_wmask = vecs[i].mask; wb_csr_wvalue = vecs[i].val;
            settle();
            check($sformatf("vec%0d_csr_we", i), {31'b0, csr_we}, {31'b0, vecs[i].e_we});
            check($sformatf("vec%0d_wb_ex", i), {31'b0, wb_ex}, {31'b0, vecs[i].e_ex});
            check($sformatf("vec%0d_ecode", i), {26'b0, wb_ecode}, {26'b0, vecs[i].e_ecode});
            check($sformatf("vec%0d_esubcode", i), {23'b0, wb_esubcode}, 32'h0);
            check($sformatf("vec%0d_ertn_flush", i), {31'b0, ertn_flush}, {31'b0, vecs[i].e_ertn});
            check($sformatf("vec%0d_ex_pc", i), ex_pc, vecs[i].e_ex ? vecs[i].pc : 32'h0);
            check($sformatf("vec%0d_ex_vaddr", i), ex_vaddr, vecs[i].e_va);
            if (vecs[i].e_we) begin
                check($sformatf("vec%0d_csr_num", i), {18'b0, csr_num}, {18'b0, vecs[i].num});
                check($sformatf("vec%0d_csr_wmask", i), csr_wmask, vecs[i].mask);
                check($sformatf("vec%0d_csr_wvalue", i), csr_wvalue, vecs[i].val);
            end
            tick();
            quiet_inputs();
            settle();
            check($sformatf("vec%0d_flush_valid", i), {31'b0, flush_valid}, {31'b0, vecs[i].e_redir});
            if (vecs[i].e_redir)
                check($sformatf("vec%0d_flush_target", i), flush_target, vecs[i].e_tgt);
            return_idle($sformatf("vec%0d_back_idle", i));
        end

        // SYS with flush_ack held: exactly two REDIR cycles.
        flush_ack = 1'b1;
        wb_valid = 1'b1; wb_pc = 32'h1C00_0100; wb_exc = 5'b00100;
        settle();
        check("sys_wb_ex", {31'b0, wb_ex}, 32'h1);
        check("sys_ecode", {26'b0, wb_ecode}, 32'h0B);
        check("sys_ex_pc", ex_pc, 32'h1C00_0100);
        tick();
        quiet_inputs();
        settle();
        check("sys_redir1", {31'b0, flush_valid}, 32'h1);
        check("sys_target", flush_target, EX_ENTRY);
        tick();
        settle();
        check("sys_redir2", {31'b0, flush_valid}, 32'h1);
        tick();
        settle();
        check("sys_exit", {31'b0, flush_valid}, 32'h0);
        flush_ack = 1'b0;

        // Interrupt pulse, then an ertn accepted next cycle takes INT.
        has_int = 1'b1;
        tick();
        has_int = 1'b0;
        wb_valid = 1'b1; wb_pc = 32'h1C00_0300; wb_ertn = 1'b1;
        settle();
        check("int_wb_ex", {31'b0, wb_ex}, 32'h1);
        check("int_ecode", {26'b0, wb_ecode}, 32'h00);
        check("int_no_ertn", {31'b0, ertn_flush}, 32'h0);
        tick();
        quiet_inputs();
        // has_int during REDIR, including the exit edge, must not latch.
        has_int = 1'b1;
        settle();
        check("int_target", flush_target, EX_ENTRY);
        return_idle("int_back_idle");
        has_int = 1'b0;
        wb_valid = 1'b1; wb_csr_we = 1'b1; wb_csr_num = 14'h5;
        settle();
        check("int_cleared_ex", {31'b0, wb_ex}, 32'h0);
        check("int_cleared_we", {31'b0, csr_we}, 32'h1);
        tick();
        quiet_inputs();

        // ertn, then squash during a long REDIR.
        wb_valid = 1'b1; wb_ertn = 1'b1; wb_pc = 32'h1C00_0400;
        settle();
        check("ertn_flush", {31'b0, ertn_flush}, 32'h1);
        tick();
        quiet_inputs();
        for (int c = 0; c < 4; c++) begin
            wb_valid = 1'b1; wb_csr_we = 1'b1; wb_csr_num = 14'h30; wb_exc = 5'b00100; wb_ertn = 1'b1;
            settle();
            check($sformatf("sq%0d_flush_valid", c), {31'b0, flush_valid}, 32'h1);
            check($sformatf("sq%0d_target", c), flush_target, ERTN_ENTRY);
            check($sformatf("sq%0d_csr_we", c), {31'b0, csr_we}, 32'h0);
            check($sformatf("sq%0d_wb_ex", c), {31'b0, wb_ex}, 32'h0);
            check($sformatf("sq%0d_ertn", c), {31'b0, ertn_flush}, 32'h0);
            check($sformatf("sq%0d_allowin", c), {31'b0, wb_allowin}, 32'h1);
            tick();
        end
        quiet_inputs();
        // Counter saturated: a single ack cycle exits.
        flush_ack = 1'b1;
        tick();
        flush_ack = 1'b0;
        settle();
        check("sq_ack_exit", {31'b0, flush_valid}, 32'h0);

        // Reset while in REDIR.
        wb_valid = 1'b1; wb_exc = 5'b00010; wb_pc = 32'h1C00_0500;
        tick();
        quiet_inputs();
        settle();
        check("rr_in_redir", {31'b0, flush_valid}, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        check("rr_flush_valid", {31'b0, flush_valid}, 32'h0);
        check("rr_flush_target", flush_target, 32'h0);
        wb_valid = 1'b1; wb_csr_we = 1'b1; wb_csr_num = 14'h31; wb_csr_wmask = 32'hF; wb_csr_wvalue = 32'h77;
        settle();
        check("rr_csr_we", {31'b0, csr_we}, 32'h1);
        check("rr_csr_num", {18'b0, csr_num}, 32'h31);
        check("rr_csr_wvalue", csr_wvalue, 32'h77);
        tick();
        quiet_inputs();
        settle();
        check("rr_stay_idle", {31'b0, flush_valid}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
